// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the main-memory port arbiter.
// Used by arb_pick3 and mem_port_arbiter.
package mem_arb_pkg;

  // Burst sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Select codes for the 4-to-1 address/data mux in front of memory.
  // SEL_IDLE picks the mux's constant-zero leg.
  localparam logic [1:0] SEL_IREFILL = 2'b00;
  localparam logic [1:0] SEL_DREFILL = 2'b01;
  localparam logic [1:0] SEL_WBACK   = 2'b10;
  localparam logic [1:0] SEL_IDLE    = 2'b11;

  // Requester bit positions in req/grant/done.
  // Each index equals that requester's mux select code.
  localparam int REQ_IREFILL = 0;
  localparam int REQ_DREFILL = 1;
  localparam int REQ_WBACK   = 2;

  localparam int DEF_BLOCK_WORDS = 4;

endpackage

// File: rtl/arb_pick3.sv
// Combinational winner selection among the three memory requesters.
// With MEM_ARB_RR_EN defined, the search is round-robin and starts
// just after rr_ptr. Otherwise it is fixed priority:
// write-back > D-refill > I-refill.
module arb_pick3
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
`ifdef MEM_ARB_RR_EN
  input  logic [1:0] rr_ptr,
`endif
  output logic [2:0] gnt,
  output logic [1:0] sel
);

`ifdef MEM_ARB_RR_EN
  logic [1:0] start;
  logic [2:0] cand;
  logic       found;

  // Round-robin search starting at rr_ptr+1 mod 3. The first requester found wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    gnt   = '0;
    sel   = SEL_IDLE;
    found = 1'b0;
    cand  = '0;
    start = (rr_ptr >= 2'd2) ? 2'd0 : rr_ptr + 2'd1;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, start} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!found && req[cand[1:0]]) begin
        found = 1'b1;
        gnt   = 3'(3'b001 << cand[1:0]);
        sel   = cand[1:0];
      end
    end
  end
`else
  // Fixed priority. Write-back goes first so a dirty victim leaves before its refill.
  always_comb begin
    gnt = '0;
    sel = SEL_IDLE;
    if (req[REQ_WBACK]) begin
      gnt[REQ_WBACK] = 1'b1;
      sel            = SEL_WBACK;
    end else if (req[REQ_DREFILL]) begin
      gnt[REQ_DREFILL] = 1'b1;
      sel              = SEL_DREFILL;
    end else if (req[REQ_IREFILL]) begin
      gnt[REQ_IREFILL] = 1'b1;
      sel              = SEL_IREFILL;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single main-memory port between the I-cache refill,
// D-cache refill and D-cache write-back requesters. It runs one
// cache-line burst at a time, and all outputs come from registers.
// Optional macro MEM_ARB_RR_EN switches arbitration to round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int WCNT_W      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_sel,
  output logic [2:0]        grant,
  output logic [WCNT_W-1:0] word_cnt,
  output logic [2:0]        done
);

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(BLOCK_WORDS - 1);

  state_e              state_q,    state_d;
  logic                mem_req_q,  mem_req_d;
  logic                mem_we_q,   mem_we_d;
  logic [1:0]          mem_sel_q,  mem_sel_d;
  logic [2:0]          grant_q,    grant_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [2:0]          done_q,     done_d;
  logic [2:0]          pick_gnt;
  logic [1:0]          pick_sel;
`ifdef MEM_ARB_RR_EN
  logic [1:0]          rr_ptr_q,   rr_ptr_d;
`endif

  arb_pick3 u_pick (
    .req    (req),
`ifdef MEM_ARB_RR_EN
    .rr_ptr (rr_ptr_q),
`endif
    .gnt    (pick_gnt),
    .sel    (pick_sel)
  );

  // Next-state and next-output logic of the burst sequencer.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_sel_d  = mem_sel_q;
    grant_d    = grant_q;
    word_cnt_d = word_cnt_q;
    done_d     = '0;
`ifdef MEM_ARB_RR_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = BURST;
          mem_req_d  = 1'b1;
          mem_we_d   = pick_gnt[REQ_WBACK];
          mem_sel_d  = pick_sel;
          grant_d    = pick_gnt;
          word_cnt_d = '0;
`ifdef MEM_ARB_RR_EN
          rr_ptr_d   = pick_sel;
`endif
        end else begin
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_sel_d  = SEL_IDLE;
          grant_d    = '0;
          word_cnt_d = '0;
        end
      end
      BURST: begin
        if (mem_ready) begin
          if (word_cnt_q == LAST_WORD) begin
            state_d    = DONE;
            mem_req_d  = 1'b0;
            mem_we_d   = 1'b0;
            mem_sel_d  = SEL_IDLE;
            grant_d    = '0;
            word_cnt_d = '0;
            done_d     = grant_q;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Asynchronous reset returns everything to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the edge.
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_sel_q  <= SEL_IDLE;
      grant_q    <= '0;
      word_cnt_q <= '0;
      done_q     <= '0;
`ifdef MEM_ARB_RR_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_sel_q  <= mem_sel_d;
      grant_q    <= grant_d;
      word_cnt_q <= word_cnt_d;
      done_q     <= done_d;
`ifdef MEM_ARB_RR_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_sel  = mem_sel_q;
  assign grant    = grant_q;
  assign word_cnt = word_cnt_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Inputs are driven just after the falling edge, and outputs are
// checked at the following falling edge.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic [1:0] mem_sel;
  logic [2:0] grant;
  logic [1:0] word_cnt;
  logic [2:0] done;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(.BLOCK_WORDS(4), .WCNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .grant     (grant),
    .word_cnt  (word_cnt),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // The packed layout is {mem_req, mem_we, mem_sel, grant, word_cnt, done}.
  task automatic expect_out(input string tag, input logic rq, input logic we,
                            input logic [1:0] sel, input logic [2:0] gnt,
                            input logic [1:0] wc, input logic [2:0] dn);
    check(tag, {20'd0, mem_req, mem_we, mem_sel, grant, word_cnt, done},
               {20'd0, rq, we, sel, gnt, wc, dn});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One full burst with mem_ready held high. The caller has already driven req.
  // The task checks each word, the done cycle, and the idle bubble that follows.
  task automatic run_burst(input string tag, input logic [2:0] gnt,
                           input logic [1:0] sel, input logic drop);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out($sformatf("%s_w%0d", tag, i), 1'b1, gnt[2], sel, gnt, 2'(i), 3'b000);
    end
    tick();
    expect_out({tag, "_done"}, 1'b0, 1'b0, 2'b11, 3'b000, 2'd0, gnt);
    if (drop) req = req & ~gnt;
    tick();
    expect_out({tag, "_bubble"}, 1'b0, 1'b0, 2'b11, 3'b000, 2'd0, 3'b000);
  endtask

  logic [6:0] stall_pat;
  logic [1:0] stall_wc [7];

  initial begin
    req       = 3'b000;
    mem_ready = 1'b0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #1 expect_out("reset_async", 1'b0, 1'b0, 2'b11, 3'b000, 2'd0, 3'b000);
    tick(); tick();
    rst_n = 1'b1;

    // Idle with no requests. mem_ready is driven high and must be ignored.
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_out($sformatf("idle_%0d", i), 1'b0, 1'b0, 2'b11, 3'b000, 2'd0, 3'b000);
    end

    // Single I-cache refill.
    req = 3'b001;
    run_burst("irefill", 3'b001, 2'b00, 1'b1);

    // Stalled write-back. The ready pattern is applied oldest first.
    stall_pat = 7'b1011001;   // bit0 first: 1,0,0,1,1,0,1
    stall_wc[0] = 2'd1; stall_wc[1] = 2'd1; stall_wc[2] = 2'd1;
    stall_wc[3] = 2'd2; stall_wc[4] = 2'd3; stall_wc[5] = 2'd3;
    req = 3'b100;
    mem_ready = 1'b0;
    tick();
    expect_out("wb_start", 1'b1, 1'b1, 2'b10, 3'b100, 2'd0, 3'b000);
    for (int i = 0; i < 6; i++) begin
      mem_ready = stall_pat[i];
      tick();
      expect_out($sformatf("wb_stall_%0d", i), 1'b1, 1'b1, 2'b10, 3'b100, stall_wc[i], 3'b000);
    end
    mem_ready = stall_pat[6];
    tick();
    expect_out("wb_done", 1'b0, 1'b0, 2'b11, 3'b000, 2'd0, 3'b100);
    req = 3'b000;
    tick();
    expect_out("wb_after", 1'b0, 1'b0, 2'b11, 3'b000, 2'd0, 3'b000);

`ifndef MEM_ARB_RR_EN
    // Three-way contention under fixed priority. Each winner drops req after its done.
    req = 3'b111;
    run_burst("prio_wb", 3'b100, 2'b10, 1'b1);
    run_burst("prio_dr", 3'b010, 2'b01, 1'b1);
    run_burst("prio_ir", 3'b001, 2'b00, 1'b1);
    tick();
    expect_out("prio_end", 1'b0, 1'b0, 2'b11, 3'b000, 2'd0, 3'b000);
`else
    // Round-robin with both refills held. Reset first so rr_ptr starts at 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 3'b011;
    run_burst("rr_1", 3'b010, 2'b01, 1'b0);
    run_burst("rr_2", 3'b001, 2'b00, 1'b0);
    run_burst("rr_3", 3'b010, 2'b01, 1'b0);
    req = 3'b000;
    tick();
    expect_out("rr_end", 1'b0, 1'b0, 2'b11, 3'b000, 2'd0, 3'b000);
`endif

    // Reset lands mid-burst at word 2. No done may follow, and the held req restarts the burst from word 0.
    req = 3'b010;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("mid_w%0d", i), 1'b1, 1'b0, 2'b01, 3'b010, 2'(i), 3'b000);
    end
    rst_n = 1'b0;
    #1 expect_out("mid_rst_async", 1'b0, 1'b0, 2'b11, 3'b000, 2'd0, 3'b000);
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_out($sformatf("mid_rst_hold_%0d", i), 1'b0, 1'b0, 2'b11, 3'b000, 2'd0, 3'b000);
    end
    rst_n = 1'b1;
    run_burst("mid_restart", 3'b010, 2'b01, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
